// File: rtl/glyph_pkg.sv
// Shared helpers for the glyph renderer: width derivation and scale encoding.
// Pure declarations, no logic; imported by every renderer file.
// Widths derived here size the text/font address ports.
package glyph_pkg;

  typedef enum logic [1:0] {
    SCALE_1X     = 2'd0,
    SCALE_2X     = 2'd1,
    SCALE_4X     = 2'd2,
    SCALE_4X_ALT = 2'd3
  } scale_e;

  // ceil(log2(v)), never less than 1 so derived fields are never empty
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ta_width(input int cols, input int rows);
    return clog2(cols * rows);
  endfunction

  function automatic int font_aw(input int code_w, input int glyph_h);
    return code_w + clog2(glyph_h);
  endfunction

  // Right-shift amount for a scale code; the spare code behaves as 4x
  function automatic logic [1:0] scale_shift(input scale_e s);
    case (s)
      SCALE_1X: return 2'd0;
      SCALE_2X: return 2'd1;
      default:  return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/glyph_delay_line.sv
// Shift register aligning sideband fields with the render datapath.
// Latency DEPTH cycles; output is the input delayed DEPTH clocks.
// No backpressure: shifts every cycle, reset clears every stage.
module glyph_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  // Advance one stage per cycle; stage 0 takes the new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/glyph_render_pipe.sv
// Text overlay: raster position -> text cell -> font row -> one glyph pixel.
// Fixed 5-cycle latency from in_* to out_*; syncs delayed through the same pipe.
// No stalls: every stage advances each cycle, back-to-back pixels supported.
module glyph_render_pipe
  import glyph_pkg::*;
#(
  parameter int  GLYPH_W      = 8,
  parameter int  GLYPH_H      = 16,
  parameter int  CODE_W       = 7,
  parameter int  TEXT_COLS    = 80,
  parameter int  TEXT_ROWS    = 30,
  parameter int  X_W          = 11,
  parameter int  Y_W          = 10,
  parameter int  BLINK_FRAMES = 30,
  localparam int TA_W         = ta_width(TEXT_COLS, TEXT_ROWS),
  localparam int FA_W         = font_aw(CODE_W, GLYPH_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         scale,
  input  logic               in_valid,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic               in_hsync,
  input  logic               in_vsync,
  output logic [TA_W-1:0]    text_addr,
  input  logic [7:0]         text_data,
  output logic [FA_W-1:0]    font_addr,
  input  logic [GLYPH_W-1:0] font_data,
  output logic               out_valid,
  output logic               out_pix,
  output logic               out_hsync,
  output logic               out_vsync
);

  localparam int GB   = clog2(GLYPH_W);
  localparam int GR   = clog2(GLYPH_H);
  localparam int BW   = clog2(BLINK_FRAMES);
  localparam int S2_W = 4 + GB + GR;  // valid, blank, hsync, vsync, gcol, grow
  localparam int S4_W = 4 + GB;       // grow no longer needed after font address

  scale_e        scale_q;
  logic          vsync_q;
  logic          vsync_rise;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  assign vsync_rise = in_vsync & ~vsync_q;

  // Frame-rate state: scale latch and blink phase both step on vsync rise only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      scale_q   <= SCALE_1X;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      vsync_q <= in_vsync;
      if (vsync_rise) begin
        scale_q <= scale_e'(scale);
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // S0: scaled position split into text cell and in-glyph coordinates
  logic [1:0]        shamt;
  logic [X_W-1:0]    sx;
  logic [Y_W-1:0]    sy;
  logic [X_W-GB-1:0] ccol;
  logic [Y_W-GR-1:0] crow;
  logic [GB-1:0]     gcol0;
  logic [GR-1:0]     grow0;
  logic              blank0;
  logic [TA_W-1:0]   addr0;

  // Cell lookup; addr0 is only meaningful when blank0 is low
  always_comb begin
    shamt  = scale_shift(scale_q);
    sx     = in_x >> shamt;
    sy     = in_y >> shamt;
    ccol   = sx[X_W-1:GB];
    crow   = sy[Y_W-1:GR];
    gcol0  = sx[GB-1:0];
    grow0  = sy[GR-1:0];
    blank0 = (int'(ccol) >= TEXT_COLS) || (int'(crow) >= TEXT_ROWS);
    addr0  = TA_W'(int'(crow) * TEXT_COLS + int'(ccol));
  end

  // Text-buffer address: issued for on-grid pixels only, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_addr <= '0;
    end else if (in_valid && !blank0) begin
      text_addr <= addr0;
    end
  end

  logic [S2_W-1:0] s2_bus;
  logic            s2_valid, s2_blank, s2_hsync, s2_vsync;
  logic [GB-1:0]   s2_gcol;
  logic [GR-1:0]   s2_grow;

  glyph_delay_line #(.WIDTH(S2_W), .DEPTH(2)) u_dl_s2 (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({in_valid, blank0, in_hsync, in_vsync, gcol0, grow0}),
    .dout (s2_bus)
  );

  assign {s2_valid, s2_blank, s2_hsync, s2_vsync, s2_gcol, s2_grow} = s2_bus;

  logic blink_attr;
  logic blink_d;

  // Font address from the returned code; blink attribute tracks the same pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_addr  <= '0;
      blink_attr <= 1'b0;
      blink_d    <= 1'b0;
    end else begin
      if (s2_valid && !s2_blank) begin
        font_addr <= {text_data[CODE_W-1:0], s2_grow};
      end
      blink_attr <= text_data[7];
      blink_d    <= blink_attr;
    end
  end

  logic [S4_W-1:0] s4_bus;
  logic            s4_valid, s4_blank, s4_hsync, s4_vsync;
  logic [GB-1:0]   s4_gcol;
  logic [GB-1:0]   bit_idx;
  logic            glyph_bit;

  glyph_delay_line #(.WIDTH(S4_W), .DEPTH(2)) u_dl_s4 (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({s2_valid, s2_blank, s2_hsync, s2_vsync, s2_gcol}),
    .dout (s4_bus)
  );

  assign {s4_valid, s4_blank, s4_hsync, s4_vsync, s4_gcol} = s4_bus;
  // Font row MSB is the leftmost pixel
  assign bit_idx   = GB'(GLYPH_W - 1) - s4_gcol;
  assign glyph_bit = font_data[bit_idx];

  // Output stage: pixel forced low for invalid, blank or blinked-off cells
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_pix   <= 1'b0;
    end else begin
      out_valid <= s4_valid;
      out_hsync <= s4_hsync;
      out_vsync <= s4_vsync;
      out_pix   <= s4_valid & ~s4_blank & glyph_bit & ~(blink_d & blink_off);
    end
  end

endmodule

// File: tb/tb_glyph_render_pipe.sv
// Self-checking bench for glyph_render_pipe: directed steps plus random runs
// compared against a per-pixel arithmetic model of the text overlay.
// External text buffer and font ROM are modelled with 1-cycle read latency.
module tb_glyph_render_pipe;

  localparam int LAT = 5;
  localparam int BF  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  scale;
  logic        in_valid;
  logic [10:0] in_x;
  logic [9:0]  in_y;
  logic        in_hsync, in_vsync;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        out_valid, out_pix, out_hsync, out_vsync;

  always #5 clk = ~clk;

  glyph_render_pipe #(.BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scale    (scale),
    .in_valid (in_valid),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_hsync (in_hsync),
    .in_vsync (in_vsync),
    .text_addr(text_addr),
    .text_data(text_data),
    .font_addr(font_addr),
    .font_data(font_data),
    .out_valid(out_valid),
    .out_pix  (out_pix),
    .out_hsync(out_hsync),
    .out_vsync(out_vsync)
  );

  logic [7:0] text_mem [2400];
  logic [7:0] font_rom [2048];

  typedef struct {
    bit v;
    bit hs;
    bit vs;
    bit pix;
  } exp_t;

  exp_t        exp_q[$];
  int          compares = 0;
  int          fails = 0;
  int          vs_edges = 0;
  int          sc_model = 0;
  bit          vs_prev = 1'b0;
  logic [1:0]  sc_drive = 2'd0;
  logic [11:0] ta_prev = '0;
  logic [10:0] fa_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference pixel: divide by the scale factor, find the cell, look up the glyph
  function automatic bit model_pix(input int x, input int y, input int sc, input int edges);
    int s, px, py, col, row, code, bits;
    s   = (sc == 0) ? 1 : (sc == 1) ? 2 : 4;
    px  = x / s;
    py  = y / s;
    col = px / 8;
    row = py / 16;
    if (col >= 80 || row >= 30) return 1'b0;
    code = int'(text_mem[row * 80 + col]);
    bits = int'(font_rom[(code % 128) * 16 + py % 16]);
    if (code >= 128 && ((edges / BF) % 2 == 1)) return 1'b0;
    return bits[7 - px % 8];
  endfunction

  // One clock: drive inputs, record expectation, serve memories, check output
  task automatic step(input bit v, input int x, input int y, input bit hs, input bit vs);
    exp_t e;
    exp_t f;
    in_valid = v;
    in_x     = 11'(x);
    in_y     = 10'(y);
    in_hsync = hs;
    in_vsync = vs;
    scale    = sc_drive;
    e.v   = v;
    e.hs  = hs;
    e.vs  = vs;
    e.pix = v ? model_pix(x, y, sc_model, vs_edges) : 1'b0;
    exp_q.push_back(e);
    if (vs && !vs_prev) begin
      vs_edges++;
      sc_model = int'(sc_drive);
    end
    vs_prev = vs;
    @(posedge clk);
    #1;
    text_data = text_mem[ta_prev];
    ta_prev   = text_addr;
    font_data = font_rom[fa_prev];
    fa_prev   = font_addr;
    if (exp_q.size() == LAT) begin
      f = exp_q.pop_front();
      check("out_valid", 32'(out_valid), 32'(f.v));
      check("out_hsync", 32'(out_hsync), 32'(f.hs));
      check("out_vsync", 32'(out_vsync), 32'(f.vs));
      check("out_pix",   32'(out_pix),   32'(f.pix));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Frame boundary kept clear of active pixels on both sides
  task automatic frame_edge();
    idle(6);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);
  endtask

  // Asynchronous reset from wherever the run is; outputs must clear at once
  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix",   32'(out_pix),   32'd0);
    check("rst_out_hsync", 32'(out_hsync), 32'd0);
    check("rst_out_vsync", 32'(out_vsync), 32'd0);
    check("rst_text_addr", 32'(text_addr), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    z.v = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.pix = 1'b0;
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(z);
    vs_edges = 0;
    sc_model = 0;
    vs_prev  = 1'b0;
    ta_prev  = '0;
    fa_prev  = '0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; scale = 2'd0; in_valid = 1'b0; in_x = '0; in_y = '0;
    in_hsync = 1'b0; in_vsync = 1'b0; text_data = '0; font_data = '0;
    for (int i = 0; i < 2400; i++) text_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    text_mem[162]     = 8'h41;
    font_rom[11'h413] = 8'h40;
    text_mem[0]       = 8'h85;
    font_rom[5 * 16]  = 8'hFF;
    #3;
    do_reset();

    // Basic lookup at 1x: (17,35) -> cell 2,2 -> addr 162, row 3, column 1
    step(1'b1, 17, 35, 1'b0, 1'b0);
    check("t1_text_addr", 32'(text_addr), 32'd162);
    idle(2);
    check("t1_font_addr", 32'(font_addr), 32'h413);
    idle(2);
    check("t1_out_pix", 32'(out_pix), 32'd1);

    // 2x scale latched at vsync lands (34,70) in the same cell
    sc_drive = 2'd1;
    frame_edge();
    step(1'b1, 34, 70, 1'b0, 1'b0);
    check("s2x_text_addr", 32'(text_addr), 32'd162);
    idle(4);
    check("s2x_out_pix", 32'(out_pix), 32'd1);

    // Mid-frame scale write is ignored until the next vsync
    sc_drive = 2'd2;
    step(1'b1, 34, 70, 1'b0, 1'b0);
    check("midframe_text_addr", 32'(text_addr), 32'd162);
    idle(4);
    frame_edge();
    step(1'b1, 34, 70, 1'b0, 1'b0);
    check("s4x_text_addr", 32'(text_addr), 32'd81);
    idle(4);

    // Off-grid column 80: blank pixel, address unchanged
    sc_drive = 2'd0;
    frame_edge();
    step(1'b1, 640, 35, 1'b0, 1'b0);
    check("blank_text_addr", 32'(text_addr), 32'd81);
    idle(4);
    check("blank_out_valid", 32'(out_valid), 32'd1);
    check("blank_out_pix",   32'(out_pix),   32'd0);

    // Blink: on for two frames, off for two, on again
    do_reset();
    for (int f = 0; f < 5; f++) begin
      step(1'b1, 0, 0, 1'b0, 1'b0);
      idle(4);
      check($sformatf("blink_f%0d", f), 32'(out_pix), 32'(((f / BF) % 2) == 0));
      frame_edge();
    end

    // Continuous run over a cell boundary with an hsync pulse in the middle
    for (int i = 0; i < 16; i++) step(1'b1, 4 + i, 40, (i >= 6 && i < 9), 1'b0);
    idle(6);

    // Reset in the middle of a run
    for (int i = 0; i < 5; i++) step(1'b1, 100 + i, 50, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 200 + i, 60, 1'b0, 1'b0);
    idle(6);

    // Random frames: random scale, runs of pixels, sparse hsync
    for (int fr = 0; fr < 6; fr++) begin
      sc_drive = 2'($urandom_range(0, 3));
      frame_edge();
      for (int k = 0; k < 50; k++) begin
        bit v;
        int x0, y0, len;
        v   = ($urandom_range(0, 3) != 0);
        x0  = int'($urandom_range(0, 1500));
        y0  = int'($urandom_range(0, 1023));
        len = int'($urandom_range(1, 12));
        for (int j = 0; j < len; j++) step(v, x0 + j, y0, ($urandom_range(0, 7) == 0), 1'b0);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/glyph_render_pipe.md
Name: glyph_render_pipe

Overview:
Parametrised text-overlay renderer for the display path. It takes a raster pixel position and maps it to a character cell, then reads the character code from the text buffer. It then forms the font-ROM address from {code, glyph row} and selects one glyph pixel. It generalises the fixed 8-column digit-font address map with configurable glyph size, text grid, integer pixel scaling, blink attribute and a latency-matched sync pipeline.

Parameters:
GLYPH_W, 8, glyph width in pixels (power of 2)
GLYPH_H, 16, glyph height in pixels (power of 2)
CODE_W, 7, character-code width used for font addressing
TEXT_COLS, 80, text grid columns
TEXT_ROWS, 30, text grid rows
X_W, 11, pixel x width
Y_W, 10, pixel y width
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scale  in  2  0=1x, 1=2x, 2=4x, 3 treated as 4x
in_valid  in  1  active-video pixel
in_x  in  X_W  pixel column
in_y  in  Y_W  pixel row
in_hsync  in  1  hsync, passed through
in_vsync  in  1  vsync, passed through, active high
text_addr  out  TA_W=clog2(TEXT_COLS*TEXT_ROWS)  text-buffer read address
text_data  in  8  text-buffer data, 1-cycle read latency; [CODE_W-1:0]=code, [7]=blink
font_addr  out  CODE_W+clog2(GLYPH_H)  font-ROM address {code, glyph_row}
font_data  in  GLYPH_W  font row, 1-cycle latency, MSB = leftmost pixel
out_valid  out  1  delayed in_valid
out_pix  out  1  rendered pixel
out_hsync  out  1  delayed hsync
out_vsync  out  1  delayed vsync

Behaviour:
- Reset: every output and all pipeline registers are 0. scale_q=0 (1x), blink counter=0, blink phase=on.
- scale is latched into scale_q on each in_vsync rising edge only. A mid-frame change takes effect the next frame.
- S0 (input cycle N):
  - sx = in_x >> scale_q, sy = in_y >> scale_q
  - ccol = sx >> log2(GLYPH_W), crow = sy >> log2(GLYPH_H)
  - gcol = sx mod GLYPH_W, grow = sy mod GLYPH_H
  - blank = (ccol >= TEXT_COLS) | (crow >= TEXT_ROWS)
- Edge into N+1: if in_valid & ~blank, text_addr <= crow*TEXT_COLS + ccol. Otherwise text_addr holds. gcol, grow, blank and valid advance regardless.
- Edge into N+3: if the stage is valid and not blank, font_addr <= {text_data[CODE_W-1:0], grow}. Otherwise font_addr holds. blink_attr <= text_data[7].
- Edge into N+5: out_pix <= valid & ~blank & font_data[GLYPH_W-1-gcol] & ~(blink_attr & blink_off).
- Fixed latency: 5 cycles from input to out_*. out_valid, out_hsync and out_vsync are delayed by exactly 5 cycles through the same shift pipeline.
- out_pix is 0 whenever out_valid is 0.
- Blink: a frame counter increments on each in_vsync rising edge. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- No stalls: the pipeline advances every cycle. Back-to-back pixels and cell-boundary crossings must produce no bubbles.
- Reset mid-line: pipeline flushes to 0. Outputs stay 0 until 5 cycles after valid input resumes.
- Simultaneous vsync edge and scale change: the new scale is captured on that edge.

Decomposition:
- Package glyph_pkg: clog2 helper, TA_W and font-address-width derivation, scale encoding constants (SCALE_1X/2X/4X).
- Sub-module glyph_delay_line (parametrised width/depth shift register with async reset) for the valid/sync/gcol/grow/blank alignment.

Test Plan:
- Defaults, scale=0, in_x=17, in_y=35 valid: text_addr=162 at N+1. With text_data=0x41: font_addr={0x41,4'd3}=0x413 at N+3. With font_data=0b0100_0000: out_pix=1 at N+5 (gcol=1).
- scale=1 latched at vsync, in_x=34, in_y=70: same cell (text_addr=162, grow=3, gcol=1). Scale written mid-frame has no effect until the next vsync.
- in_x=640 (ccol=80), scale=0: blank, out_valid=1, out_pix=0, text_addr unchanged.
- text_data[7]=1, glyph bit set, BLINK_FRAMES=2: out_pix visible for frames 0-1, 0 for frames 2-3, visible again for frame 4.
- Continuous 16-pixel run across a cell boundary with a hsync pulse: out_hsync edge exactly 5 cycles after input, no pixel gap. Assert rst_n low mid-run: all outputs 0 within the same cycle.
